// File: rtl/fft_bitrev_reorder.sv
// Reorders one FFT frame from bit-reversed arrival order to natural order.
// Whole-frame ping: fill N points into storage, then drain them in order.
module fft_bitrev_reorder #(
    parameter int N         = 8,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done
);
    localparam int IDX_SIZE = $clog2(N);
    localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(N - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [IDX_SIZE-1:0]   wr_cnt, rd_cnt;
    logic [WORD_SIZE-1:0]  mem [N];
    logic                  wr_en, rd_en;

    function automatic logic [IDX_SIZE-1:0] bitrev(input logic [IDX_SIZE-1:0] x);
        logic [IDX_SIZE-1:0] r;
        for (int i = 0; i < IDX_SIZE; i++) r[i] = x[IDX_SIZE-1-i];
        return r;
    endfunction

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    // Handshake outputs decode straight from state so reset forces them at once.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        state_nxt = state;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wr_cnt == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = mem[rd_cnt];
                if (out_ready && rd_cnt == LAST_IDX) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Counters wrap naturally at N since N is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (wr_en) wr_cnt <= wr_cnt + IDX_SIZE'(1);
            if (rd_en) rd_cnt <= rd_cnt + IDX_SIZE'(1);
            frame_done <= rd_en && (rd_cnt == LAST_IDX);
        end
    end

    // Storage is never exposed outside DRAIN, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[bitrev(wr_cnt)] <= in_data;
    end
endmodule
